// File: rtl/bp_pkg.sv
// Shared definitions for the gshare/BTB branch predictor.
// Holds the mode encoding, counter reset/saturation values and the PC field
// extraction helpers. The index and tag helpers return 32-bit values; callers
// size-cast them to their own field widths.
package bp_pkg;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    // Instructions are word aligned, so the low two PC bits carry no information.
    localparam int unsigned BP_PC_ALIGN = 2;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int unsigned ctr_reset_val(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_max_val(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_bits);
        return (pc >> BP_PC_ALIGN) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_bits,
                                           input int unsigned tag_bits);
        return (pc >> (BP_PC_ALIGN + index_bits)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Table of saturating direction counters.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-low reset (all counters -> weakly not-taken)
//   rd_en_i, rd_idx_i     read request; the counter is registered into rd_ctr_o, which holds otherwise
//   rd_ctr_o              registered counter value
//   upd_en_i, upd_idx_i   training request for one entry
//   upd_taken_i           1 = count up (saturate at all-ones), 0 = count down (saturate at 0)
// A read and an update of the same entry in one cycle return the pre-update value.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rd_en_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic [CTR_BITS-1:0]   rd_ctr_o,
    input  logic                  upd_en_i,
    input  logic [INDEX_BITS-1:0] upd_idx_i,
    input  logic                  upd_taken_i
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max_val(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [CTR_BITS-1:0] rd_ctr_q, rd_ctr_d;

    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c, input logic up);
        if (up) begin
            return (c == CTR_MAX) ? c : c + 1'b1;
        end
        return (c == '0) ? c : c - 1'b1;
    endfunction

    always_comb begin
        ctr_d    = ctr_q;
        rd_ctr_d = rd_ctr_q;
        if (rd_en_i) begin
            rd_ctr_d = ctr_q[rd_idx_i];
        end
        if (upd_en_i) begin
            ctr_d[upd_idx_i] = sat_step(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RST;
            end
            rd_ctr_q <= '0;
        end else begin
            ctr_q    <= ctr_d;
            rd_ctr_q <= rd_ctr_d;
        end
    end

    assign rd_ctr_o = rd_ctr_q;

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare/bimodal direction predictor with a direct-mapped tagged BTB.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-low reset
//   mode_i           0 = bimodal (PC index), 1 = gshare (PC xor history)
//   lkp_*            one lookup per cycle; answered on pred_* one cycle later
//   pred_valid_o     pulses for one cycle per lookup; other pred_* hold between lookups
//   pred_hist_o      history used by the lookup, returned later on upd_hist_i
//   upd_*            training from branch resolve (counter, BTB, history, statistics)
//   ghr_o            committed global history, newest outcome in the MSB
//   stat_upd_o/stat_miss_o  saturating update / mispredict counters
module gshare_btb_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS   = 8,
    parameter int HISTORY_SIZE = 8,
    parameter int CTR_BITS     = 2,
    parameter int TAG_BITS     = 8,
    parameter int STAT_BITS    = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    mode_i,
    input  logic                    lkp_valid_i,
    input  logic [31:0]             lkp_pc_i,
    output logic                    pred_valid_o,
    output logic                    pred_taken_o,
    output logic [31:0]             pred_pc_o,
    output logic [HISTORY_SIZE-1:0] pred_hist_o,
    input  logic                    upd_valid_i,
    input  logic [31:0]             upd_pc_i,
    input  logic [HISTORY_SIZE-1:0] upd_hist_i,
    input  logic                    upd_taken_i,
    input  logic [31:0]             upd_target_i,
    input  logic                    upd_pred_taken_i,
    input  logic [31:0]             upd_pred_pc_i,
    output logic [HISTORY_SIZE-1:0] ghr_o,
    output logic [STAT_BITS-1:0]    stat_upd_o,
    output logic [STAT_BITS-1:0]    stat_miss_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                  gshare_mode;
    logic [INDEX_BITS-1:0] lkp_pcidx, lkp_dir_idx, upd_pcidx, upd_dir_idx;
    logic [TAG_BITS-1:0]   lkp_tag, upd_tag;
    logic [CTR_BITS-1:0]   rd_ctr;

    assign gshare_mode = (bp_mode_e'(mode_i) == BP_GSHARE);
    assign lkp_pcidx   = INDEX_BITS'(pc_index(lkp_pc_i, INDEX_BITS));
    assign upd_pcidx   = INDEX_BITS'(pc_index(upd_pc_i, INDEX_BITS));
    assign lkp_tag     = TAG_BITS'(pc_tag(lkp_pc_i, INDEX_BITS, TAG_BITS));
    assign upd_tag     = TAG_BITS'(pc_tag(upd_pc_i, INDEX_BITS, TAG_BITS));

    // Lookups hash with the live history; updates hash with the snapshot the lookup used,
    // so training lands on the entry that produced the prediction.
    logic [HISTORY_SIZE-1:0] ghr_q, ghr_d;
    assign lkp_dir_idx = gshare_mode ? (lkp_pcidx ^ INDEX_BITS'(ghr_q)) : lkp_pcidx;
    assign upd_dir_idx = gshare_mode ? (upd_pcidx ^ INDEX_BITS'(upd_hist_i)) : upd_pcidx;

    bp_sat_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_ctr_table (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rd_en_i     (lkp_valid_i),
        .rd_idx_i    (lkp_dir_idx),
        .rd_ctr_o    (rd_ctr),
        .upd_en_i    (upd_valid_i),
        .upd_idx_i   (upd_dir_idx),
        .upd_taken_i (upd_taken_i)
    );

    // BTB: only valid bits need a reset; tag/target are qualified by valid.
    logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_BITS-1:0] btb_tag_q [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_d [ENTRIES];
    logic [31:0]         btb_tgt_q [ENTRIES];
    logic [31:0]         btb_tgt_d [ENTRIES];
    logic                btb_we, lkp_hit;

    assign btb_we  = upd_valid_i & upd_taken_i;
    assign lkp_hit = btb_valid_q[lkp_pcidx] && (btb_tag_q[lkp_pcidx] == lkp_tag);

    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        if (btb_we) begin
            btb_valid_d[upd_pcidx] = 1'b1;
            btb_tag_d[upd_pcidx]   = upd_tag;
            btb_tgt_d[upd_pcidx]   = upd_target_i;
        end
    end

    // Lookup response registers. The counter MSB arrives registered from the table, so the
    // final direction/next-PC select is done on registered values.
    logic                    pred_valid_q, pred_valid_d;
    logic [HISTORY_SIZE-1:0] pred_hist_q, pred_hist_d;
    logic                    lkp_hit_q, lkp_hit_d;
    logic [31:0]             lkp_tgt_q, lkp_tgt_d;
    logic [31:0]             lkp_seq_q, lkp_seq_d;
    logic [STAT_BITS-1:0]    stat_upd_q, stat_upd_d, stat_miss_q, stat_miss_d;
    logic                    mispredict;

    assign mispredict = (upd_taken_i != upd_pred_taken_i) ||
                        (upd_taken_i && (upd_pred_pc_i != upd_target_i));

    always_comb begin
        pred_valid_d = lkp_valid_i;
        pred_hist_d  = pred_hist_q;
        lkp_hit_d    = lkp_hit_q;
        lkp_tgt_d    = lkp_tgt_q;
        lkp_seq_d    = lkp_seq_q;
        ghr_d        = ghr_q;
        stat_upd_d   = stat_upd_q;
        stat_miss_d  = stat_miss_q;
        if (lkp_valid_i) begin
            pred_hist_d = ghr_q;
            lkp_hit_d   = lkp_hit;
            lkp_tgt_d   = btb_tgt_q[lkp_pcidx];
            lkp_seq_d   = lkp_pc_i + 32'd4;
        end
        if (upd_valid_i) begin
            ghr_d      = HISTORY_SIZE'({upd_taken_i, ghr_q} >> 1);
            stat_upd_d = sat_inc(stat_upd_q);
            if (mispredict) begin
                stat_miss_d = sat_inc(stat_miss_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            btb_valid_q  <= '0;
            pred_valid_q <= 1'b0;
            pred_hist_q  <= '0;
            lkp_hit_q    <= 1'b0;
            lkp_tgt_q    <= '0;
            lkp_seq_q    <= '0;
            ghr_q        <= '0;
            stat_upd_q   <= '0;
            stat_miss_q  <= '0;
        end else begin
            btb_valid_q  <= btb_valid_d;
            pred_valid_q <= pred_valid_d;
            pred_hist_q  <= pred_hist_d;
            lkp_hit_q    <= lkp_hit_d;
            lkp_tgt_q    <= lkp_tgt_d;
            lkp_seq_q    <= lkp_seq_d;
            ghr_q        <= ghr_d;
            stat_upd_q   <= stat_upd_d;
            stat_miss_q  <= stat_miss_d;
        end
    end

    always_ff @(posedge clk_i) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = rd_ctr[CTR_BITS-1] & lkp_hit_q;
    assign pred_pc_o    = pred_taken_o ? lkp_tgt_q : lkp_seq_q;
    assign pred_hist_o  = pred_hist_q;
    assign ghr_o        = ghr_q;
    assign stat_upd_o   = stat_upd_q;
    assign stat_miss_o  = stat_miss_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: directed scenarios plus randomized traffic, all
// compared against a table-level reference model of the predictor.
module tb_gshare_btb_predictor;

    localparam int IB = 8;
    localparam int HS = 8;
    localparam int SB = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          mode_i;
    logic          lkp_valid_i;
    logic [31:0]   lkp_pc_i;
    logic          pred_valid_o;
    logic          pred_taken_o;
    logic [31:0]   pred_pc_o;
    logic [HS-1:0] pred_hist_o;
    logic          upd_valid_i;
    logic [31:0]   upd_pc_i;
    logic [HS-1:0] upd_hist_i;
    logic          upd_taken_i;
    logic [31:0]   upd_target_i;
    logic          upd_pred_taken_i;
    logic [31:0]   upd_pred_pc_i;
    logic [HS-1:0] ghr_o;
    logic [SB-1:0] stat_upd_o;
    logic [SB-1:0] stat_miss_o;

    gshare_btb_predictor #(
        .INDEX_BITS(IB), .HISTORY_SIZE(HS), .CTR_BITS(2), .TAG_BITS(8), .STAT_BITS(SB)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .mode_i(mode_i),
        .lkp_valid_i(lkp_valid_i), .lkp_pc_i(lkp_pc_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
        .pred_pc_o(pred_pc_o), .pred_hist_o(pred_hist_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_hist_i(upd_hist_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .upd_pred_taken_i(upd_pred_taken_i), .upd_pred_pc_i(upd_pred_pc_i),
        .ghr_o(ghr_o), .stat_upd_o(stat_upd_o), .stat_miss_o(stat_miss_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: 256 two-bit counters as plain ints, BTB as arrays, history as int.
    int          m_ctr [256];
    bit          m_bv  [256];
    int          m_btag[256];
    logic [31:0] m_btgt[256];
    int          m_ghr, m_upd, m_miss;
    bit          e_valid, e_taken;
    logic [31:0] e_pc;
    int          e_hist;

    function automatic int pidx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd255);
    endfunction
    function automatic int ptag(input logic [31:0] pc);
        return int'((pc >> 10) & 32'd255);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_ctr[i] = 1;
            m_bv[i]  = 0;
        end
        m_ghr = 0; m_upd = 0; m_miss = 0;
        e_valid = 0; e_taken = 0; e_pc = 0; e_hist = 0;
    endtask

    task automatic check_outs(input string p);
        chk({p, "_valid"}, pred_valid_o, e_valid);
        chk({p, "_taken"}, pred_taken_o, e_taken);
        chk({p, "_pc"}, pred_pc_o, e_pc);
        chk({p, "_hist"}, pred_hist_o, e_hist);
        chk({p, "_ghr"}, ghr_o, m_ghr);
        chk({p, "_stat_upd"}, stat_upd_o, m_upd);
        chk({p, "_stat_miss"}, stat_miss_o, m_miss);
    endtask

    // Evaluate the model on the currently driven inputs, clock once, compare.
    task automatic tick(input string p);
        int di, bi;
        bit mis;
        e_valid = lkp_valid_i;
        if (lkp_valid_i) begin
            bi = pidx(lkp_pc_i);
            di = mode_i ? (bi ^ m_ghr) : bi;
            e_taken = (m_ctr[di] >= 2) && m_bv[bi] && (m_btag[bi] == ptag(lkp_pc_i));
            e_pc    = e_taken ? m_btgt[bi] : lkp_pc_i + 32'd4;
            e_hist  = m_ghr;
        end
        if (upd_valid_i) begin
            bi = pidx(upd_pc_i);
            di = mode_i ? (bi ^ int'(upd_hist_i)) : bi;
            if (upd_taken_i) begin
                if (m_ctr[di] < 3) m_ctr[di]++;
                m_bv[bi] = 1; m_btag[bi] = ptag(upd_pc_i); m_btgt[bi] = upd_target_i;
            end else if (m_ctr[di] > 0) begin
                m_ctr[di]--;
            end
            m_ghr = (m_ghr >> 1) | (upd_taken_i ? 128 : 0);
            mis = (upd_taken_i != upd_pred_taken_i) ||
                  (upd_taken_i && (upd_pred_pc_i != upd_target_i));
            if (m_upd < 15) m_upd++;
            if (mis && m_miss < 15) m_miss++;
        end
        @(posedge clk_i);
        #1;
        check_outs(p);
    endtask

    task automatic idle();
        lkp_valid_i = 0; upd_valid_i = 0;
    endtask

    task automatic drive(input bit lk, input logic [31:0] lpc, input bit up, input logic [31:0] upc,
                         input bit tk, input logic [31:0] tgt, input logic [HS-1:0] hist);
        lkp_valid_i = lk; lkp_pc_i = lpc;
        upd_valid_i = up; upd_pc_i = upc; upd_taken_i = tk; upd_target_i = tgt;
        upd_hist_i = hist; upd_pred_taken_i = tk; upd_pred_pc_i = tgt;
    endtask

    task automatic do_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                          input logic [HS-1:0] hist);
        drive(0, 0, 1, pc, tk, tgt, hist);
        tick("upd");
        idle();
    endtask

    task automatic do_lkp(input logic [31:0] pc);
        drive(1, pc, 0, 0, 0, 0, 0);
        tick("lkp");
        idle();
    endtask

    task automatic do_reset();
        reset_i = 0;
        #1;
        model_reset();
        check_outs("rst_async");
        @(posedge clk_i);
        #1;
        check_outs("rst_hold");
        reset_i = 1;
    endtask

    initial begin
        reset_i = 0; mode_i = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_outs("reset");
        reset_i = 1;
        tick("idle");

        // Bimodal training, saturation at the bottom.
        do_upd(32'h100, 1, 32'h400, 0);
        do_upd(32'h100, 1, 32'h400, 0);
        do_lkp(32'h100);
        chk("train_taken", pred_taken_o, 1);
        chk("train_pc", pred_pc_o, 32'h400);
        for (int i = 0; i < 3; i++) do_upd(32'h100, 0, 32'h400, 0);
        do_lkp(32'h100);
        chk("untrain_taken", pred_taken_o, 0);
        chk("untrain_pc", pred_pc_o, 32'h104);
        do_upd(32'h100, 0, 32'h400, 0);
        do_upd(32'h100, 1, 32'h400, 0);
        do_lkp(32'h100);
        chk("ctr_nowrap", pred_taken_o, 0);

        // Gshare separation on history 0x00 vs 0x01.
        mode_i = 1;
        for (int i = 0; i < 2; i++) do_upd(32'h100, 1, 32'h400, 8'h00);
        for (int i = 0; i < 2; i++) do_upd(32'h100, 0, 32'h400, 8'h01);
        for (int i = 0; i < 8; i++) do_upd(32'h800, 0, 32'h900, 8'h80);
        chk("gs_ghr0", ghr_o, 8'h00);
        do_lkp(32'h100);
        chk("gs_h0_taken", pred_taken_o, 1);
        chk("gs_h0_pc", pred_pc_o, 32'h400);
        do_upd(32'h800, 1, 32'h900, 8'h80);
        for (int i = 0; i < 7; i++) do_upd(32'h800, 0, 32'h900, 8'h80);
        chk("gs_ghr1", ghr_o, 8'h01);
        do_lkp(32'h100);
        chk("gs_h1_taken", pred_taken_o, 0);
        chk("gs_h1_hist", pred_hist_o, 8'h01);

        // BTB tag miss on an aliasing PC whose counter predicts taken.
        mode_i = 0;
        do_lkp(32'h100 + (32'd1 << (IB + 2)));
        chk("tagmiss_taken", pred_taken_o, 0);
        chk("tagmiss_pc", pred_pc_o, 32'h504);

        // Same-cycle lookup and taken update: lookup sees the old counter.
        do_upd(32'h100, 0, 32'h400, 0);
        do_upd(32'h100, 0, 32'h400, 0);
        drive(1, 32'h100, 1, 32'h100, 1, 32'h400, 0);
        tick("coll");
        idle();
        chk("coll_old", pred_taken_o, 0);
        do_lkp(32'h100);
        chk("coll_new", pred_taken_o, 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            mode_i           = 1'($urandom_range(0, 1));
            lkp_valid_i      = 1'($urandom_range(0, 1));
            lkp_pc_i         = 32'h100 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 1)) << 10);
            upd_valid_i      = 1'($urandom_range(0, 1));
            upd_pc_i         = 32'h100 + (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 1)) << 10);
            upd_hist_i       = HS'($urandom_range(0, 3));
            upd_taken_i      = 1'($urandom_range(0, 1));
            upd_target_i     = ($urandom_range(0, 1) != 0) ? 32'h400 : $urandom;
            upd_pred_taken_i = 1'($urandom_range(0, 1));
            upd_pred_pc_i    = ($urandom_range(0, 1) != 0) ? upd_target_i : 32'h404;
            tick("rnd");
        end
        idle();
        mode_i = 0;

        // Reset pulse with a lookup response in flight.
        do_upd(32'h100, 1, 32'h400, 0);
        do_lkp(32'h100);
        do_reset();
        lkp_valid_i = 1; lkp_pc_i = 32'h100;
        #1;
        chk("post_rst_valid_pre", pred_valid_o, 0);
        tick("post_rst");
        idle();
        chk("post_rst_taken", pred_taken_o, 0);
        chk("post_rst_pc", pred_pc_o, 32'h104);
        chk("post_rst_valid", pred_valid_o, 1);
        tick("post_rst_idle");
        chk("post_rst_valid_drop", pred_valid_o, 0);

        // History shift order: newest outcome enters at the MSB.
        do_upd(32'h200, 1, 32'h300, 0);
        chk("ghr_seq0", ghr_o, 8'h80);
        do_upd(32'h200, 0, 32'h300, 0);
        chk("ghr_seq1", ghr_o, 8'h40);
        do_upd(32'h200, 1, 32'h300, 0);
        chk("ghr_seq2", ghr_o, 8'hA0);

        // Statistics saturate at all-ones.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 32'h300, 1, 32'h500, 0);
            upd_pred_taken_i = 0;
            tick("stat");
        end
        idle();
        chk("stat_upd_sat", stat_upd_o, 15);
        chk("stat_miss_sat", stat_miss_o, 15);
        tick("stat_hold");
        chk("stat_upd_hold", stat_upd_o, 15);
        chk("stat_miss_hold", stat_miss_o, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
